// File: rtl/weight_loader.sv
// weight_loader: serial-to-parallel weight assembler for the convolver.
// Collects N words over valid/ready and commits them as one packed vector.
module weight_loader #(
    parameter int N          = 9,
    parameter int DATA_WIDTH = 16,
    parameter int CW         = $clog2(N + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ready,
    input  logic                    abort,
    output logic [N*DATA_WIDTH-1:0] weight_write,
    output logic                    write,
    output logic [CW-1:0]           count,
    output logic [15:0]             sets_loaded
);

    typedef enum logic {
        LOAD   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    state_t                  state;
    logic [N*DATA_WIDTH-1:0] staging;
    logic [N*DATA_WIDTH-1:0] assembled;
    logic                    accept;
    logic                    last;

    // ready only while loading, and never while reset is held
    assign in_ready = (state == LOAD) && !reset;
    assign accept   = in_ready && in_valid && !abort;
    assign last     = (count == CW'(N - 1));

    // staging image with the incoming word dropped into its slot
    always_comb begin
        assembled = staging;
        for (int k = 0; k < N; k++) begin
            if (count == CW'(k)) begin
                assembled[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
            end
        end
    end

    // load/commit sequencer; the output vector moves only on a commit edge
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= LOAD;
            count        <= '0;
            staging      <= '0;
            weight_write <= '0;
            write        <= 1'b0;
            sets_loaded  <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    write <= 1'b0;
                    if (abort) begin
                        count <= '0;
                    end else if (accept) begin
                        staging <= assembled;
                        if (last) begin
                            weight_write <= assembled;
                            count        <= '0;
                            sets_loaded  <= sets_loaded + 16'd1;
                            write        <= 1'b1;
                            state        <= COMMIT;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                COMMIT: begin
                    write <= 1'b0;
                    state <= LOAD;
                end
                default: begin
                    write <= 1'b0;
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed and random stimulus for weight_loader,
// checked every cycle against a queue-based model of the loader.
module tb_weight_loader;

    localparam int N  = 9;
    localparam int DW = 16;
    localparam int VW = N * DW;
    localparam int CW = 4;

    localparam logic [VW-1:0] V1 =
        144'h0009_0008_0007_0006_0005_0004_0003_0002_0001;
    localparam logic [VW-1:0] VB =
        144'h0B09_0B08_0B07_0B06_0B05_0B04_0B03_0B02_0B01;

    logic          clock    = 1'b0;
    logic          reset    = 1'b1;
    logic          in_valid = 1'b0;
    logic          abort    = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_ready;
    logic [VW-1:0] weight_write;
    logic          write;
    logic [CW-1:0] count;
    logic [15:0]   sets_loaded;
    logic [VW-1:0] weight_read;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    logic [DW-1:0] m_words[$];
    logic [VW-1:0] m_vec    = '0;
    logic [VW-1:0] m_rd     = '0;
    logic [15:0]   m_sets   = '0;
    bit            m_commit = 1'b0;

    weight_loader #(.N(N), .DATA_WIDTH(DW), .CW(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .abort        (abort),
        .weight_write (weight_write),
        .write        (write),
        .count        (count),
        .sets_loaded  (sets_loaded)
    );

    always #5 clock = ~clock;

    // downstream weight_register stand-in
    always @(posedge clock) begin
        if (reset) weight_read <= '0;
        else if (write) weight_read <= weight_write;
    end

    task automatic chk(input string name, input logic [VW-1:0] act,
                       input logic [VW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired", name);
    endtask

    // model: accepted words queue up; N of them make a committed vector
    always @(posedge clock) begin
        if (reset) begin
            m_words.delete();
            m_vec    = '0;
            m_rd     = '0;
            m_sets   = '0;
            m_commit = 1'b0;
        end else begin
            if (m_commit) begin
                m_rd     = m_vec;
                m_commit = 1'b0;
            end else if (abort) begin
                m_words.delete();
            end else if (in_valid) begin
                m_words.push_back(in_data);
                if (m_words.size() == N) begin
                    for (int k = 0; k < N; k++) m_vec[k*DW +: DW] = m_words[k];
                    m_words.delete();
                    m_sets++;
                    m_commit = 1'b1;
                end
            end
        end
        #1;
        chk("in_ready", in_ready, !reset && !m_commit);
        chk("write", write, m_commit);
        chk("weight_write", weight_write, m_vec);
        chk("count", count, VW'(m_words.size()));
        chk("sets_loaded", sets_loaded, m_sets);
        chk("weight_read", weight_read, m_rd);
    end

    // present a word and hold it until the loader is ready for it
    task automatic send(input logic [DW-1:0] d);
        int n;
        n = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = d;
        abort    = 1'b0;
        while (!in_ready) begin
            n++;
            if (n > 4) begin
                fail_note("send_ready");
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic rand_cycle(input bit allow_abort);
        @(negedge clock);
        if (in_ready || !in_valid) begin
            in_valid = ($urandom_range(3) != 0);
            in_data  = DW'($urandom);
        end
        abort = allow_abort && ($urandom_range(31) == 0);
    endtask

    initial begin
        logic [15:0] prev;
        bit wrapped;

        in_valid = 1'b1;
        in_data  = 16'h1234;
        repeat (5) begin
            @(negedge clock);
            chk("rst_ready", in_ready, 1'b0);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rel_ready", in_ready, 1'b1);
        chk("rel_vec", weight_write, '0);
        chk("rel_write", write, 1'b0);
        chk("rel_count", count, '0);
        chk("rel_sets", sets_loaded, '0);
        @(negedge clock);

        // back-to-back set
        for (int i = 1; i <= 9; i++) send(DW'(i));
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = 16'h00AA;
        chk("b2b_write", write, 1'b1);
        chk("b2b_vec", weight_write, V1);
        chk("b2b_ready", in_ready, 1'b0);
        chk("b2b_sets", sets_loaded, VW'(1));
        @(negedge clock);
        chk("b2b_ready2", in_ready, 1'b1);
        chk("b2b_read", weight_read, V1);
        @(negedge clock);
        in_valid = 1'b0;
        chk("aa_count", count, VW'(1));
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("clr_count", count, '0);

        // gapped set
        for (int i = 1; i <= 9; i++) begin
            send(DW'(i));
            if (i < 9) begin
                @(negedge clock);
                in_valid = 1'b0;
                in_data  = DW'($urandom);
                chk("gap_count", count, VW'(i));
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
        chk("gap_write", write, 1'b1);
        chk("gap_vec", weight_write, V1);
        chk("gap_sets", sets_loaded, VW'(2));

        // abort a partial set, then load B
        for (int i = 1; i <= 4; i++) send(DW'(16'h0100 + i));
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        abort    = 1'b1;
        @(negedge clock);
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abt_count", count, '0);
        chk("abt_hold", weight_write, V1);
        chk("abt_write", write, 1'b0);
        for (int i = 1; i <= 9; i++) send(DW'(16'h0B00 + i));
        @(negedge clock);
        in_valid = 1'b0;
        chk("b_write", write, 1'b1);
        chk("b_vec", weight_write, VB);
        chk("b_sets", sets_loaded, VW'(3));

        // reset mid-set
        for (int i = 1; i <= 6; i++) send(DW'(16'h0C00 + i));
        @(negedge clock);
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("mid_ready", in_ready, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        chk("mid_vec", weight_write, '0);
        chk("mid_count", count, '0);
        chk("mid_write", write, 1'b0);

        // reset during the commit cycle
        for (int i = 1; i <= 9; i++) send(DW'(16'h0D00 + i));
        @(negedge clock);
        reset    = 1'b1;
        in_valid = 1'b0;
        chk("cmt_write", write, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        chk("cmt_write2", write, 1'b0);
        chk("cmt_sets", sets_loaded, '0);
        chk("cmt_vec", weight_write, '0);

        // random traffic with occasional aborts
        repeat (3000) rand_cycle(1'b1);

        // preload the commit counter near its wrap point
        @(negedge clock);
        in_valid = 1'b0;
        abort    = 1'b0;
        force dut.sets_loaded = 16'hFFFD;
        m_sets = 16'hFFFD;
        #1;
        release dut.sets_loaded;
        chk("preload", sets_loaded, VW'(16'hFFFD));
        prev    = sets_loaded;
        wrapped = 1'b0;
        for (int c = 0; c < 500; c++) begin
            rand_cycle(1'b0);
            if (prev == 16'hFFFF && sets_loaded != 16'hFFFF) begin
                chk("wrap", sets_loaded, '0);
                wrapped = 1'b1;
            end
            prev = sets_loaded;
            if (wrapped && sets_loaded == 16'h0002) break;
        end
        if (!wrapped) fail_note("wrap_timeout");

        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        fail_note("watchdog");
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
